clk_div_multi: RTL and testbench

Multi-channel programmable clock divider; parametrised successor to the fixed divide-by-12 CPLD divider. Generates CHANNELS divided clocks from `clk_in`, each with a runtime-writable divisor, per-channel enable, a one-cycle tick strobe per output period, and a global realignment input. Divisor changes take effect only at a period boundary, so outputs never glitch. Sits in the CPLD clock section and feeds CPU/video/serial timing.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_chan.sv | 68 ++++++
 rtl/clk_div_multi.sv | 67 ++++++
 tb/tb_clk_div_multi.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int DIV_MIN = 2;

  // Width of a channel index: clog2 of the channel count, never less than 1.
  function automatic int chan_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, registered clock and tick.
module clk_div_chan #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pend
);

  logic [WIDTH-1:0] div_reg, cnt_reg, pend_div_reg, cnt_next;
  logic             clk_out_reg, tick_reg, pend_reg;
  logic             last, boundary;
  logic [WIDTH:0]   high_len;

  always_comb begin
    last     = (cnt_reg == div_reg - WIDTH'(1));
    cnt_next = last ? '0 : cnt_reg + WIDTH'(1);
    high_len = ({1'b0, div_reg} + (WIDTH+1)'(1)) >> 1;
    boundary = en && (sync || last);
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_reg      <= WIDTH'(DEFAULT_DIV);
      cnt_reg      <= WIDTH'(DEFAULT_DIV - 1);
      pend_div_reg <= WIDTH'(DEFAULT_DIV);
      clk_out_reg  <= 1'b0;
      tick_reg     <= 1'b0;
      pend_reg     <= 1'b0;
    end else begin
      if (en) begin
        if (sync) begin
          cnt_reg     <= '0;
          clk_out_reg <= 1'b1;
          tick_reg    <= 1'b1;
        end else begin
          cnt_reg     <= cnt_next;
          clk_out_reg <= ({1'b0, cnt_next} < high_len);
          tick_reg    <= (cnt_next == '0);
        end
      end else begin
        tick_reg <= 1'b0;
      end
      // New divisor only lands on a period boundary; cnt=0 is high for any D.
      if (boundary && pend_reg) begin
        div_reg  <= pend_div_reg;
        pend_reg <= 1'b0;
      end
      // A write coinciding with a boundary is held for the next one.
      if (wr) begin
        pend_div_reg <= wr_div;
        pend_reg     <= 1'b1;
      end
    end
  end

  assign clk_out = clk_out_reg;
  assign tick    = tick_reg;
  assign pend    = pend_reg;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: write decode, error strobe and
// one clk_div_chan per output.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 12
) (
  input  logic                            clk_in,
  input  logic                            reset,
  input  logic [CHANNELS-1:0]             en,
  input  logic                            sync,
  input  logic                            wr_en,
  input  logic [chan_width(CHANNELS)-1:0] wr_chan,
  input  logic [WIDTH-1:0]                wr_div,
  output logic [CHANNELS-1:0]             clk_out,
  output logic [CHANNELS-1:0]             tick,
  output logic [CHANNELS-1:0]             pend,
  output logic                            err
);

  localparam int CW = chan_width(CHANNELS);

  if (CHANNELS < 1 || CHANNELS > 8) begin : g_bad_channels
    $error("clk_div_multi: CHANNELS must be within 1..8");
  end
  if (DEFAULT_DIV < DIV_MIN || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
    $error("clk_div_multi: DEFAULT_DIV must be within 2..2^WIDTH-1");
  end

  logic wr_ok;
  logic err_reg;

  assign wr_ok = (wr_div >= WIDTH'(DIV_MIN)) && (32'(wr_chan) < CHANNELS);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= wr_en && !wr_ok;
    end
  end

  assign err = err_reg;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic wr;
    assign wr = wr_en && wr_ok && (wr_chan == CW'(gi));

    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk_in  (clk_in),
      .reset   (reset),
      .en      (en[gi]),
      .sync    (sync),
      .wr      (wr),
      .wr_div  (wr_div),
      .clk_out (clk_out[gi]),
      .tick    (tick[gi]),
      .pend    (pend[gi])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi; three channels so that an out-of-range
// channel index (3) is representable on the 2-bit wr_chan port.
module tb_clk_div_multi;

  localparam int CH = 3;
  localparam int W  = 8;
  localparam int CW = 2;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [CH-1:0] en;
  logic          sync;
  logic          wr_en;
  logic [CW-1:0] wr_chan;
  logic [W-1:0]  wr_div;
  logic [CH-1:0] clk_out, tick, pend;
  logic          err;

  int checks = 0;
  int errors = 0;

  clk_div_multi #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(12)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .wr_en   (wr_en),
    .wr_chan (wr_chan),
    .wr_div  (wr_div),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend),
    .err     (err)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic          we;
    logic [CW-1:0] ch;
    logic [W-1:0]  d;
    logic [2:0]    exp_clk;
    logic [2:0]    exp_tick;
    logic [2:0]    exp_pend;
    logic          exp_err;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic we, input logic [CW-1:0] ch, input logic [W-1:0] d,
                              input logic [2:0] c, input logic [2:0] t, input logic [2:0] p,
                              input logic e);
    vec_t v;
    v.we = we; v.ch = ch; v.d = d;
    v.exp_clk = c; v.exp_tick = t; v.exp_pend = p; v.exp_err = e;
    return v;
  endfunction

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [2:0] c, input logic [2:0] t,
                         input logic [2:0] p, input logic e);
    chk({name, ".clk"},  int'(clk_out), int'(c));
    chk({name, ".tick"}, int'(tick),    int'(t));
    chk({name, ".pend"}, int'(pend),    int'(p));
    chk({name, ".err"},  int'(err),     int'(e));
  endtask

  initial begin
    int hi, lo, n;
    bit seen;

    // Edges after reset release: D=12 everywhere, ch1 reprogrammed to 5 at edge 3.
    vecs[0] = mk(0, 0, 0, 3'b111, 3'b111, 3'b000, 0);
    vecs[1] = mk(0, 0, 0, 3'b111, 3'b000, 3'b000, 0);
    vecs[2] = mk(1, 1, 5, 3'b111, 3'b000, 3'b010, 0);
    for (int i = 3; i <= 5; i++)  vecs[i] = mk(0, 0, 0, 3'b111, 3'b000, 3'b010, 0);
    for (int i = 6; i <= 11; i++) vecs[i] = mk(0, 0, 0, 3'b000, 3'b000, 3'b010, 0);
    vecs[12] = mk(0, 0, 0, 3'b111, 3'b111, 3'b000, 0);
    vecs[13] = mk(0, 0, 0, 3'b111, 3'b000, 3'b000, 0);
    vecs[14] = mk(0, 0, 0, 3'b111, 3'b000, 3'b000, 0);
    vecs[15] = mk(0, 0, 0, 3'b101, 3'b000, 3'b000, 0);
    vecs[16] = mk(0, 0, 0, 3'b101, 3'b000, 3'b000, 0);
    vecs[17] = mk(0, 0, 0, 3'b111, 3'b010, 3'b000, 0);
    vecs[18] = mk(0, 0, 0, 3'b010, 3'b000, 3'b000, 0);
    vecs[19] = mk(1, 0, 1, 3'b010, 3'b000, 3'b000, 1);
    vecs[20] = mk(1, 3, 7, 3'b000, 3'b000, 3'b000, 1);
    vecs[21] = mk(0, 0, 0, 3'b000, 3'b000, 3'b000, 0);
    vecs[22] = mk(1, 1, 0, 3'b010, 3'b010, 3'b000, 1);
    vecs[23] = mk(0, 0, 0, 3'b010, 3'b000, 3'b000, 0);
    vecs[24] = mk(0, 0, 0, 3'b111, 3'b101, 3'b000, 0);

    reset = 1'b1; en = '0; sync = 1'b0; wr_en = 1'b0; wr_chan = '0; wr_div = '0;
    step();
    step();
    chk_all("reset", 3'b000, 3'b000, 3'b000, 1'b0);
    $display("reset clk=%b tick=%b pend=%b err=%b", clk_out, tick, pend, err);

    reset = 1'b0; en = 3'b111;
    for (int i = 0; i < 25; i++) begin
      wr_en = vecs[i].we; wr_chan = vecs[i].ch; wr_div = vecs[i].d;
      step();
      $display("vec %0d we=%b ch=%0d d=%0d clk=%b tick=%b pend=%b err=%b",
               i, vecs[i].we, vecs[i].ch, vecs[i].d, clk_out, tick, pend, err);
      chk_all($sformatf("vec%0d", i), vecs[i].exp_clk, vecs[i].exp_tick,
              vecs[i].exp_pend, vecs[i].exp_err);
    end
    wr_en = 1'b0;

    // Freeze ch0 at cnt=1 (high phase) for 7 cycles.
    step();
    chk("freeze.pre", int'(clk_out[0]), 1);
    en = 3'b110;
    for (int i = 0; i < 7; i++) begin
      step();
      $display("freeze %0d clk=%b tick=%b", i, clk_out, tick);
      chk("freeze.clk", int'(clk_out[0]), 1);
      chk("freeze.tick", int'(tick[0]), 0);
    end
    en = 3'b111;
    hi = 0; n = 0;
    do begin
      step(); n++;
      if (clk_out[0]) hi++;
    end while (clk_out[0] && n < 20);
    chk("resume.high", hi, 4);
    lo = 1; seen = 1'b0;
    while (!seen && n < 40) begin
      step(); n++;
      if (tick[0]) seen = 1'b1;
      else lo++;
    end
    chk("resume.low", lo, 6);
    chk("resume.tick", int'(seen), 1);
    $display("resume high=%0d low=%0d tick=%0d", hi, lo, seen);

    // Realign: ch1 to D=8, then sync; ticks coincide every 24 cycles.
    wr_en = 1'b1; wr_chan = 2'd1; wr_div = 8'd8;
    step();
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    sync = 1'b1;
    step();
    sync = 1'b0;
    $display("sync clk=%b tick=%b pend=%b", clk_out, tick, pend);
    chk_all("sync", 3'b111, 3'b111, 3'b000, 1'b0);
    for (int k = 1; k <= 24; k++) begin
      step();
      chk($sformatf("sync%0d.tick0", k), int'(tick[0]), int'(k % 12 == 0));
      chk($sformatf("sync%0d.tick1", k), int'(tick[1]), int'(k % 8 == 0));
      chk($sformatf("sync%0d.clk1", k), int'(clk_out[1]), int'((k % 8) < 4));
    end
    $display("sync run done tick=%b", tick);

    // Reset mid-period with a pending write discards it.
    wr_en = 1'b1; wr_chan = 2'd0; wr_div = 8'd3;
    step();
    wr_en = 1'b0;
    chk("prereset.pend", int'(pend[0]), 1);
    reset = 1'b1;
    step();
    $display("midreset clk=%b tick=%b pend=%b err=%b", clk_out, tick, pend, err);
    chk_all("midreset", 3'b000, 3'b000, 3'b000, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      step();
      chk($sformatf("post%0d.tick", k), int'(tick), (k == 1 || k == 13) ? 7 : 0);
      chk($sformatf("post%0d.clk", k), int'(clk_out), (((k - 1) % 12) < 6) ? 7 : 0);
    end
    $display("postreset tick=%b pend=%b", tick, pend);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
